s2p_receiver: RTL and testbench
===============================

// Module: s2p_receiver
// PURPOSE
//  - Serial-to-parallel receiver for the USB host/slave datapath.
//  - On a start request it shifts in DATA_WIDTH serial bits, one per 1x clock, MSB first.
//  - It then presents the assembled word on dataOut and pulses done.
//  - Sits between the line bit-recovery logic and the packet/byte handling layer.
// PARAMETERS
//  - DATA_WIDTH  16  number of serial bits per frame; width of dataOut (legal: 2..64)
// PORTS
//  - clk1x        input   1           1x bit clock; all logic on rising edge (codebase "1xclk", legalised)
//  - reset        input   1           asynchronous, active-high reset
//  - dataSIN      input   1           serial data in; sampled on rising clk1x
//  - receiveFlag  input   1           start request; level, sampled only in IDLE
//  - done         output  1           one-cycle pulse: frame complete, dataOut valid
//  - dataOut      output  DATA_WIDTH  last completed word; held until next completion
//  - parityErr    output  1           present only with S2P_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, high):
//    - state=IDLE, shift register=0, bit counter=0.
//    - dataOut=0, done=0, parityErr=0.
//    - A reset mid-frame aborts the frame; no done pulse is produced.
//  - FSM states IDLE, RECV, DONE; all outputs are registered.
//  - IDLE: receiveFlag=1 at an edge -> RECV with counter cleared. The bit on dataSIN at that same edge is NOT sampled.
//  - RECV:
//    - Each edge does shreg <= {shreg[DATA_WIDTH-2:0], dataSIN}, counter++. The first bit received lands in dataOut[MSB].
//    - On the edge that captures bit DATA_WIDTH-1 (final data bit):
//      - dataOut <= the completed word.
//      - done <= 1.
//      - State -> DONE.
//  - DONE:
//    - done <= 0; state -> IDLE.
//    - done is high exactly one cycle.
//  - Latency: receiveFlag sampled at edge N; bits sampled at edges N+1..N+DATA_WIDTH; done high for the cycle after edge N+DATA_WIDTH.
//  - receiveFlag is ignored in RECV and DONE; deasserting it mid-frame does not abort.
//  - receiveFlag held high continuously gives back-to-back frames, separated by the DONE and IDLE cycles (2 idle bit times).
//  - The bit counter is ceil(log2(DATA_WIDTH+1)) bits wide and never wraps within a frame.
//  - dataOut changes only on the completion edge (or reset). Intermediate shift contents are never visible.
// CONFIGURATION
//  - Macro S2P_PARITY_EN.
//    - Defined:
//      - RECV captures one extra bit (even parity) after the data bits.
//      - done is delayed by one cycle.
//      - Port parityErr is added: it goes high with done when XOR(data bits, parity bit) != 0, and low otherwise.
//      - parityErr is updated only at completion and cleared by reset.
//    - Undefined: no parity bit, no parityErr port; behaviour exactly as above.
// TESTING
//  - Reset asserted 20ns at power-up -> dataOut=0, done=0. Reset released -> both stay 0 with receiveFlag=0.
//  - receiveFlag pulsed one cycle, then dataSIN alternates 1,0,1,0... for 16 bits -> dataOut=16'hAAAA, single-cycle done 17 cycles after the start edge.
//  - Serial 16'h1234 MSB first -> dataOut=16'h1234. Then 16'h00FF -> dataOut=16'h00FF; between frames dataOut holds 16'h1234.
//  - receiveFlag held high, frames 16'hFFFF then 16'h0000 -> two done pulses 18 cycles apart, with correct words each.
//  - Reset asserted after 8 bits of frame 16'hABCD -> no done pulse, dataOut=0. A new frame 16'h5A5A then completes correctly.
//  - With S2P_PARITY_EN: 16'h0001 + parity 1 -> parityErr=0; 16'h0001 + parity 0 -> parityErr=1; done arrives 18 cycles after start.

Source files
------------

// File: rtl/s2p_receiver_if.sv
// Serial receiver bundle: serial line and start request in, assembled word and done pulse out.
// S2P_PARITY_EN adds the parityErr status signal.
interface s2p_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  dataSIN;
  logic                  receiveFlag;
  logic                  done;
  logic [DATA_WIDTH-1:0] dataOut;
`ifdef S2P_PARITY_EN
  logic                  parityErr;

  modport master (output dataSIN, receiveFlag, input done, dataOut, parityErr);
  modport slave  (input dataSIN, receiveFlag, output done, dataOut, parityErr);
`else
  modport master (output dataSIN, receiveFlag, input done, dataOut);
  modport slave  (input dataSIN, receiveFlag, output done, dataOut);
`endif
endinterface

// File: rtl/s2p_receiver.sv
// Serial-to-parallel receiver: shifts DATA_WIDTH bits in MSB first, then presents the word with a one-cycle done.
// Optional S2P_PARITY_EN: one trailing even-parity bit per frame, reported on parityErr.
module s2p_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk1x,
  input  logic           reset,
  s2p_receiver_if.slave  bus
);

`ifdef S2P_PARITY_EN
  localparam int PAR_BITS = 1;
  localparam int SHREG_W  = DATA_WIDTH;
`else
  localparam int PAR_BITS = 0;
  localparam int SHREG_W  = DATA_WIDTH - 1;
`endif
  localparam int FRAME_BITS = DATA_WIDTH + PAR_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic                  w_lastBit;
  logic [SHREG_W-1:0]    r_shreg;
  logic [SHREG_W-1:0]    w_shiftNext;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] r_dataOut;
  logic [CNT_W-1:0]      r_count;
  logic                  r_done;

`ifdef S2P_PARITY_EN
  logic                  r_parityErr;

  // The data bits are already in the shift register when the parity bit arrives.
  assign w_word      = r_shreg;
  assign w_shiftNext = {r_shreg[SHREG_W-2:0], bus.dataSIN};
  assign bus.parityErr = r_parityErr;
`else
  // Without parity the final data bit is merged directly from the line.
  assign w_word      = {r_shreg, bus.dataSIN};
  assign w_shiftNext = w_word[SHREG_W-1:0];
`endif

  assign bus.dataOut = r_dataOut;
  assign bus.done    = r_done;

  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_lastBit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.receiveFlag) begin
          w_stateNext = RECV;
        end
      end
      RECV: begin
        if (r_count == CNT_W'(FRAME_BITS - 1)) begin
          w_lastBit   = 1'b1;
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // dataOut only moves on the completion edge, so partial frames never leak out.
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      r_shreg     <= '0;
      r_count     <= '0;
      r_dataOut   <= '0;
      r_done      <= 1'b0;
`ifdef S2P_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_done <= w_lastBit;
      case (r_state)
        IDLE: begin
          r_count <= '0;
        end
        RECV: begin
          r_shreg <= w_shiftNext;
          r_count <= r_count + 1'b1;
        end
        default: begin
        end
      endcase
      if (w_lastBit) begin
        r_dataOut   <= w_word;
`ifdef S2P_PARITY_EN
        r_parityErr <= ^{r_shreg, bus.dataSIN};
`endif
      end
    end
  end

endmodule

// File: tb/tb_s2p_receiver.sv
// Scoreboard bench for s2p_receiver: stimulus queues expected words, a monitor checks each done pulse.
// Parity cases are compiled in only with S2P_PARITY_EN.
module tb_s2p_receiver;

  localparam int DW = 16;
`ifdef S2P_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    logic [DW-1:0] word;
    int            doneCycle;
    logic          perr;
  } exp_t;

  logic clk1x = 1'b0;
  logic reset = 1'b1;

  exp_t          sbQ[$];
  int            testsRun    = 0;
  int            testsFailed = 0;
  int            cycle       = 0;
  logic [DW-1:0] heldExp     = '0;
  int            lastDoneCycle = -1;
  int            prevDoneCycle = -1;

  always #5 clk1x = ~clk1x;

  always @(posedge clk1x) cycle <= cycle + 1;

  s2p_receiver_if #(.DATA_WIDTH(DW)) bus ();

  s2p_receiver #(.DATA_WIDTH(DW)) dut (
    .clk1x (clk1x),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start a frame: flag sampled at edge N, bits at N+1.., done expected after edge N+DW(+parity).
  task automatic applyStimulus(input logic [DW-1:0] word, input bit holdFlag, input bit parityBit);
    exp_t e;
    @(posedge clk1x); #1;
    bus.receiveFlag = 1'b1;
    bus.dataSIN     = ~word[DW-1];
    @(posedge clk1x); #1;
    e.word      = word;
    e.doneCycle = cycle + DW + PB;
    e.perr      = (^word) ^ parityBit;
    sbQ.push_back(e);
    bus.receiveFlag = holdFlag;
    for (int i = DW - 1; i >= 0; i--) begin
      bus.dataSIN = word[i];
      @(posedge clk1x); #1;
    end
`ifdef S2P_PARITY_EN
    bus.dataSIN = parityBit;
    @(posedge clk1x); #1;
`endif
    bus.dataSIN = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && sbQ.size() != 0; i++) begin
      @(negedge clk1x); #1;
    end
    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: timeout, %0d frames still pending, expected 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  // Monitor: pops on every done pulse; otherwise dataOut must hold the last completed word.
  initial begin : monitor
    exp_t e;
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk1x);
      if (reset) begin
        prevDone = 1'b0;
      end else begin
        if (bus.done) begin
          checkOutput("donePulseWidth", 64'(prevDone), 64'd0);
          if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedDone: got done with dataOut 0x%0h, expected no done", bus.dataOut);
          end else begin
            e = sbQ.pop_front();
            checkOutput("dataOut", 64'(bus.dataOut), 64'(e.word));
            checkOutput("doneCycle", 64'(cycle), 64'(e.doneCycle));
`ifdef S2P_PARITY_EN
            checkOutput("parityErr", 64'(bus.parityErr), 64'(e.perr));
`endif
            heldExp       = e.word;
            prevDoneCycle = lastDoneCycle;
            lastDoneCycle = cycle;
          end
        end else begin
          checkOutput("dataOutHold", 64'(bus.dataOut), 64'(heldExp));
        end
        prevDone = bus.done;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.receiveFlag = 1'b0;
    bus.dataSIN     = 1'b0;

    #12;
    checkOutput("resetDataOut", 64'(bus.dataOut), 64'd0);
    checkOutput("resetDone", 64'(bus.done), 64'd0);
    #10;
    reset = 1'b0;
    repeat (3) @(negedge clk1x);
    #1;
    checkOutput("idleDataOut", 64'(bus.dataOut), 64'd0);
    checkOutput("idleDone", 64'(bus.done), 64'd0);

    applyStimulus(16'hAAAA, 1'b0, 1'b0);
    waitDrain("frameAAAA");

    applyStimulus(16'h1234, 1'b0, 1'b0);
    waitDrain("frame1234");
    repeat (3) @(posedge clk1x);
    applyStimulus(16'h00FF, 1'b0, 1'b0);
    waitDrain("frame00FF");

    applyStimulus(16'hFFFF, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    waitDrain("backToBack");
    checkOutput("backToBackSpacing", 64'(lastDoneCycle - prevDoneCycle), 64'(DW + 2 + PB));

    // Abort frame 16'hABCD after 8 bits; no done may follow.
    @(posedge clk1x); #1;
    bus.receiveFlag = 1'b1;
    @(posedge clk1x); #1;
    bus.receiveFlag = 1'b0;
    for (int i = 15; i >= 8; i--) begin
      bus.dataSIN = 16'hABCD >> i;
      @(posedge clk1x); #1;
    end
    reset   = 1'b1;
    heldExp = '0;
    #1;
    checkOutput("abortDataOut", 64'(bus.dataOut), 64'd0);
    checkOutput("abortDone", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk1x);
    #1;
    reset       = 1'b0;
    bus.dataSIN = 1'b0;
    repeat (20) @(posedge clk1x);
    applyStimulus(16'h5A5A, 1'b0, 1'b0);
    waitDrain("frame5A5A");

`ifdef S2P_PARITY_EN
    applyStimulus(16'h0001, 1'b0, 1'b1);
    waitDrain("parityGood");
    applyStimulus(16'h0001, 1'b0, 1'b0);
    waitDrain("parityBad");
`endif

    repeat (5) @(negedge clk1x);
    checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
